// File: rtl/mr1_bus_pkg.sv
// Shared types and helpers for the MR1 data-bus responder: size encodings,
// queued-response entry layout, alignment and byte-lane decode.
package mr1_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_RSV = 2'd3
    } size_e;

    // Countdown field width; bounds LATENCY to 2**CNT_W.
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
    } rsp_entry_t;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        logic mis;
        case (size)
            SIZE_B:   mis = 1'b0;
            SIZE_H:   mis = lo[0];
            SIZE_W:   mis = (lo != 2'd0);
            SIZE_RSV: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SIZE_B:   be = 4'b0001 << lo;
            SIZE_H:   be = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:   be = 4'b1111;
            SIZE_RSV: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mr1_dbus_responder_if.sv
// MR1 data-bus request/response bundle; the core is the master, the
// memory-side responder is the slave.
interface mr1_dbus_responder_if;

    logic        data_req_valid;
    logic        data_req_ready;
    logic        data_req_wr;
    logic [31:0] data_req_addr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_data;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;

    modport master (
        output data_req_valid,
        output data_req_wr,
        output data_req_addr,
        output data_req_size,
        output data_req_data,
        input  data_req_ready,
        input  data_rsp_valid,
        input  data_rsp_data
    );

    modport slave (
        input  data_req_valid,
        input  data_req_wr,
        input  data_req_addr,
        input  data_req_size,
        input  data_req_data,
        output data_req_ready,
        output data_rsp_valid,
        output data_rsp_data
    );

endinterface

// File: rtl/mr1_rsp_fifo.sv
// In-order queue of pending load responses; every entry counts down to zero
// and the head is due once its countdown has expired.
module mr1_rsp_fifo
    import mr1_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  rsp_entry_t                 push_entry_i,
    input  logic                       pop_i,
    output logic [31:0]                head_data_o,
    output logic                       head_due_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    rsp_entry_t       entries_q [DEPTH];
    rsp_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != OCC_W'(DEPTH)) || do_pop);

    assign head_data_o = entries_q[rd_ptr_q].data;
    assign head_due_o  = (count_q != '0) && (entries_q[rd_ptr_q].cnt == '0);
    assign count_o     = count_q;

    // Stale slots also count down; harmless since a push overwrites them whole.
    always_comb begin
        entries_d = entries_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].cnt != '0) begin
                entries_d[i].cnt = entries_q[i].cnt - CNT_W'(1);
            end
        end
        if (do_push) begin
            entries_d[wr_ptr_q] = push_entry_i;
        end
    end

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/mr1_dbus_responder.sv
// Memory-side model for the MR1 data bus: word-addressed backing store with
// byte-lane stores and fixed-latency, in-order load responses.
module mr1_dbus_responder
    import mr1_bus_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    mr1_dbus_responder_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       misaligned
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    // Not reset: contents survive reset and start from zero.
    logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

    size_e            req_size;
    logic [1:0]       req_lo;
    logic [IDX_W-1:0] req_idx;
    logic             req_mis;
    logic [3:0]       req_be;
    logic [31:0]      wr_data;
    logic [31:0]      merged_word;
    logic             accept;
    logic             store_en;
    logic             load_push;
    logic             pop_now;
    logic             rsp_fire;
    rsp_entry_t       push_entry;
    logic [31:0]      head_data;
    logic [OCC_W-1:0] count;
    logic             misaligned_q, misaligned_d;
    logic             unused_addr_hi;

    assign req_size       = size_e'(bus.data_req_size);
    assign req_lo         = bus.data_req_addr[1:0];
    assign req_idx        = bus.data_req_addr[2 +: IDX_W];
    assign req_mis        = is_misaligned(req_size, req_lo);
    assign req_be         = byte_en(req_size, req_lo);
    assign wr_data        = bus.data_req_data << {req_lo, 3'b000};
    assign unused_addr_hi = ^bus.data_req_addr[31:2+IDX_W];

    // A due head frees its slot this cycle, so a full queue still takes a load.
    assign bus.data_req_ready = !reset && !stall &&
                                (bus.data_req_wr || (count != OCC_W'(DEPTH)) || pop_now);

    assign accept    = bus.data_req_valid && bus.data_req_ready;
    assign store_en  = accept && bus.data_req_wr && !req_mis;
    assign load_push = accept && !bus.data_req_wr;

    always_comb begin
        merged_word = mem_q[req_idx];
        for (int unsigned lane = 0; lane < 4; lane++) begin
            if (req_be[lane]) begin
                merged_word[lane*8 +: 8] = wr_data[lane*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (store_en) begin
            mem_q[req_idx] <= merged_word;
        end
    end

    // Data is captured at acceptance, so later stores never alter a queued load.
    always_comb begin
        push_entry.data = req_mis ? '0 : mem_q[req_idx];
        push_entry.cnt  = CNT_W'(LATENCY - 1);
    end

    mr1_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i        (clock),
        .rst_i        (reset),
        .push_i       (load_push),
        .push_entry_i (push_entry),
        .pop_i        (pop_now),
        .head_data_o  (head_data),
        .head_due_o   (pop_now),
        .count_o      (count)
    );

    always_comb begin
        misaligned_d = misaligned_q | (accept && req_mis);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    // Qualify with reset so a response due in the reset cycle is dropped.
    assign rsp_fire           = pop_now && !reset;
    assign bus.data_rsp_valid = rsp_fire;
    assign bus.data_rsp_data  = rsp_fire ? head_data : '0;
    assign outstanding        = reset ? '0 : count;
    assign misaligned         = misaligned_q && !reset;

endmodule
